// File: rtl/tick_scheduler.sv
// Three-channel timebase generator: per-channel clock-enable strobes and square waves
// from a single clock. A reprogrammed divide constant is swapped in only at a period boundary.
module tick_scheduler #(
  parameter int unsigned DIV0_RST = 10,
  parameter int unsigned DIV1_RST = 100,
  parameter int unsigned DIV2_RST = 100,
  parameter bit          CASCADE  = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        run,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_sel,
  input  logic [11:0] cfg_div,
  output logic        cfg_err,
  output logic [2:0]  tick,
  output logic [2:0]  sq,
  output logic [2:0]  applied
);

  localparam int NCH = 3;
  localparam logic [11:0] DIV_RST [NCH] = '{12'(DIV0_RST), 12'(DIV1_RST), 12'(DIV2_RST)};

  logic [11:0]    act_q  [NCH];
  logic [11:0]    act_d  [NCH];
  logic [11:0]    pend_q [NCH];
  logic [11:0]    pend_d [NCH];
  logic [11:0]    cnt_q  [NCH];
  logic [11:0]    cnt_d  [NCH];
  logic [NCH-1:0] pv_q, pv_d;
  logic [NCH-1:0] sq_q, sq_d;
  logic [NCH-1:0] applied_q, applied_d;
  logic           cfg_err_q, cfg_err_d;

  logic [NCH-1:0] is_last;
  logic [NCH-1:0] step;
  logic [NCH-1:0] wrap;
  logic [NCH-1:0] wr;
  logic           accept;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      // A disabled channel (act==0) never reaches its last count.
      assign is_last[gi] = (act_q[gi] != 12'd0) && (cnt_q[gi] == act_q[gi] - 12'd1);
      assign wr[gi]      = accept && (cfg_sel == 2'(gi));
    end
  endgenerate

  // Channel 2 may step on channel 1's wrap in the same cycle; no registered delay.
  assign step = {run & (CASCADE ? is_last[1] : 1'b1), run, run};
  assign wrap = step & is_last;

  // Ready depends only on the selected pending flag, never on cfg_valid.
  always_comb begin
    cfg_ready = 1'b1;
    case (cfg_sel)
      2'd0:    cfg_ready = ~pv_q[0];
      2'd1:    cfg_ready = ~pv_q[1];
      2'd2:    cfg_ready = ~pv_q[2];
      default: cfg_ready = 1'b1;
    endcase
  end

  assign accept    = cfg_valid & cfg_ready;
  assign cfg_err_d = accept & (cfg_sel == 2'd3);

  always_comb begin
    act_d     = act_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    pv_d      = pv_q;
    applied_d = '0;
    sq_d      = '0;
    for (int i = 0; i < NCH; i++) begin
      // A write only lands when pv is clear, so it never collides with an apply below.
      if (wr[i]) begin
        pend_d[i] = cfg_div;
        pv_d[i]   = 1'b1;
      end
      if (act_q[i] == 12'd0) begin
        cnt_d[i] = 12'd0;
        if (pv_q[i]) begin
          act_d[i]     = pend_q[i];
          pv_d[i]      = 1'b0;
          applied_d[i] = 1'b1;
        end
      end else if (wrap[i]) begin
        cnt_d[i] = 12'd0;
        if (pv_q[i]) begin
          act_d[i]     = pend_q[i];
          pv_d[i]      = 1'b0;
          applied_d[i] = 1'b1;
        end
      end else if (step[i]) begin
        cnt_d[i] = cnt_q[i] + 12'd1;
      end
      // Registered so that sq lines up with the counter value it describes.
      sq_d[i] = (cnt_d[i] < (act_d[i] >> 1));
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        act_q[i]  <= DIV_RST[i];
        pend_q[i] <= 12'd0;
        cnt_q[i]  <= 12'd0;
      end
      pv_q      <= '0;
      sq_q      <= '0;
      applied_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      act_q     <= act_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      pv_q      <= pv_d;
      sq_q      <= sq_d;
      applied_q <= applied_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign tick    = wrap;
  assign sq      = sq_q;
  assign applied = applied_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: expected tick cycles are queued per channel when a scenario
// starts and popped by a negedge monitor as strobes appear; scenario tasks check the rest.
module tb_tick_scheduler;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_sel = 2'd0;
  logic [11:0] cfg_div = 12'd0;
  logic        cfg_err;
  logic [2:0]  tick;
  logic [2:0]  sq;
  logic [2:0]  applied;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  int sb [3][$];

  tick_scheduler dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .sq        (sq),
    .applied   (applied)
  );

  always #5 clk_in = ~clk_in;

  // Cycle 1 is the first cycle after the last reset edge.
  always @(negedge clk_in) begin
    int exp_c;
    if (rst) begin
      ncyc = 0;
    end else begin
      ncyc = ncyc + 1;
      for (int ch = 0; ch < 3; ch++) begin
        if (tick[ch] !== 1'b0) begin
          checks++;
          if (sb[ch].size() == 0) begin
            errors++;
            $display("FAIL tick%0d_unexpected: strobe at cycle %0d, none expected", ch, ncyc);
          end else begin
            exp_c = sb[ch].pop_front();
            if (exp_c != ncyc) begin
              errors++;
              $display("FAIL tick%0d_time: strobe at cycle %0d, expected cycle %0d", ch, ncyc, exp_c);
            end
          end
        end else if (sb[ch].size() != 0 && sb[ch][0] <= ncyc) begin
          checks++;
          errors++;
          $display("FAIL tick%0d_missed: no strobe at cycle %0d, expected cycle %0d", ch, ncyc, sb[ch][0]);
          void'(sb[ch].pop_front());
        end
      end
    end
  end

  task automatic tick_clk();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    for (int ch = 0; ch < 3; ch++) sb[ch].delete();
    cfg_valid = 1'b0;
    cfg_sel   = 2'd0;
    cfg_div   = 12'd0;
    run       = 1'b1;
    rst       = 1'b1;
    tick_clk();
    tick_clk();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b1;
    tick_clk();
    tick_clk();
    checks++; if (sq !== 3'b000)      begin errors++; $display("FAIL reset_sq: got %b expected 000", sq); end
    checks++; if (applied !== 3'b000) begin errors++; $display("FAIL reset_applied: got %b expected 000", applied); end
    checks++; if (cfg_err !== 1'b0)   begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    checks++; if (tick !== 3'b000)    begin errors++; $display("FAIL reset_tick: got %b expected 000", tick); end
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      cfg_sel = 2'(s);
      #1;
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_sel%0d: got %b expected 1", s, cfg_ready); end
    end
    cfg_sel = 2'd0;
    $display("test_reset done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_defaults();
    logic e;
    do_reset();
    for (int k = 1; k <= 3000; k++) sb[0].push_back(10 * k);
    for (int k = 1; k <= 300; k++)  sb[1].push_back(100 * k);
    for (int k = 1; k <= 3; k++)    sb[2].push_back(10000 * k);
    for (int k = 1; k <= 30000; k++) begin
      if (k >= 2 && k <= 40) begin
        e = (((k - 1) % 10) < 5);
        checks++;
        if (sq[0] !== e) begin errors++; $display("FAIL defaults_sq0: cycle %0d got %b expected %b", k, sq[0], e); end
      end
      tick_clk();
    end
    checks++;
    if (sb[0].size() + sb[1].size() + sb[2].size() != 0) begin
      errors++; $display("FAIL defaults_drain: %0d strobes outstanding, expected 0", sb[0].size() + sb[1].size() + sb[2].size());
    end
    $display("test_defaults done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reprogram();
    logic e;
    do_reset();
    sb[0].push_back(10);
    sb[0].push_back(20);
    for (int t = 24; t <= 220; t += 4) sb[0].push_back(t);
    sb[1].push_back(100);
    sb[1].push_back(200);
    for (int k = 1; k <= 220; k++) begin
      if (k == 14) begin
        cfg_sel = 2'd0; cfg_div = 12'd4; cfg_valid = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reprog_ready_accept: got %b expected 1", cfg_ready); end
      end
      if (k == 15) cfg_valid = 1'b0;
      if (k >= 15 && k <= 20) begin
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reprog_ready_pending: cycle %0d got %b expected 0", k, cfg_ready); end
      end
      if (k == 21) begin
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reprog_ready_after: got %b expected 1", cfg_ready); end
        checks++; if (applied !== 3'b001) begin errors++; $display("FAIL reprog_applied: got %b expected 001", applied); end
      end
      if (k == 20 || k == 22) begin
        checks++; if (applied !== 3'b000) begin errors++; $display("FAIL reprog_applied_idle: cycle %0d got %b expected 000", k, applied); end
      end
      if (k >= 21 && k <= 40) begin
        e = (((k - 21) % 4) < 2);
        checks++; if (sq[0] !== e) begin errors++; $display("FAIL reprog_sq0: cycle %0d got %b expected %b", k, sq[0], e); end
      end
      tick_clk();
    end
    checks++;
    if (sb[0].size() + sb[1].size() + sb[2].size() != 0) begin
      errors++; $display("FAIL reprog_drain: %0d strobes outstanding, expected 0", sb[0].size() + sb[1].size() + sb[2].size());
    end
    $display("test_reprogram done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int t = 10; t <= 420; t += 10) sb[0].push_back(t);
    sb[1].push_back(100);
    sb[1].push_back(200);
    for (int t = 250; t <= 400; t += 50) sb[1].push_back(t);
    for (int k = 1; k <= 420; k++) begin
      if (k == 100) begin
        cfg_sel = 2'd1; cfg_div = 12'd50; cfg_valid = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL wrapacc_ready_accept: got %b expected 1", cfg_ready); end
      end
      if (k == 101) begin
        cfg_valid = 1'b0;
        checks++; if (applied !== 3'b000) begin errors++; $display("FAIL wrapacc_applied_early: got %b expected 000", applied); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL wrapacc_ready_pending: got %b expected 0", cfg_ready); end
      end
      if (k == 200) begin
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL wrapacc_ready_200: got %b expected 0", cfg_ready); end
      end
      if (k == 201) begin
        checks++; if (applied !== 3'b010) begin errors++; $display("FAIL wrapacc_applied: got %b expected 010", applied); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL wrapacc_ready_after: got %b expected 1", cfg_ready); end
      end
      tick_clk();
    end
    checks++;
    if (sb[0].size() + sb[1].size() + sb[2].size() != 0) begin
      errors++; $display("FAIL wrapacc_drain: %0d strobes outstanding, expected 0", sb[0].size() + sb[1].size() + sb[2].size());
    end
    $display("test_back_to_back done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_disable();
    do_reset();
    for (int t = 10; t <= 11500; t += 10)  sb[0].push_back(t);
    for (int t = 100; t <= 11500; t += 100) sb[1].push_back(t);
    sb[2].push_back(10000);
    sb[2].push_back(10700);
    sb[2].push_back(11400);
    for (int k = 1; k <= 11500; k++) begin
      if (k == 1) begin cfg_sel = 2'd2; cfg_div = 12'd0; cfg_valid = 1'b1; end
      if (k == 2) cfg_valid = 1'b0;
      if (k == 5000) begin
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL disable_ready_pending: got %b expected 0", cfg_ready); end
      end
      if (k == 10001) begin
        checks++; if (applied !== 3'b100) begin errors++; $display("FAIL disable_applied0: got %b expected 100", applied); end
      end
      if (k >= 10001 && k <= 10051) begin
        checks++; if (sq[2] !== 1'b0) begin errors++; $display("FAIL disable_sq2: cycle %0d got %b expected 0", k, sq[2]); end
      end
      if (k == 10050) begin
        cfg_sel = 2'd2; cfg_div = 12'd7; cfg_valid = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL disable_ready_accept: got %b expected 1", cfg_ready); end
      end
      if (k == 10051) begin
        cfg_valid = 1'b0;
        checks++; if (applied !== 3'b000) begin errors++; $display("FAIL disable_applied_early: got %b expected 000", applied); end
      end
      if (k == 10052) begin
        checks++; if (applied !== 3'b100) begin errors++; $display("FAIL disable_applied7: got %b expected 100", applied); end
        checks++; if (sq[2] !== 1'b1) begin errors++; $display("FAIL disable_sq2_on: got %b expected 1", sq[2]); end
      end
      tick_clk();
    end
    checks++;
    if (sb[0].size() + sb[1].size() + sb[2].size() != 0) begin
      errors++; $display("FAIL disable_drain: %0d strobes outstanding, expected 0", sb[0].size() + sb[1].size() + sb[2].size());
    end
    $display("test_disable done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_err_freeze();
    do_reset();
    sb[0].push_back(10);
    sb[0].push_back(20);
    sb[0].push_back(30);
    for (int t = 90; t <= 300; t += 10) sb[0].push_back(t);
    sb[1].push_back(150);
    sb[1].push_back(250);
    for (int k = 1; k <= 300; k++) begin
      if (k == 5) begin
        cfg_sel = 2'd3; cfg_div = 12'd5; cfg_valid = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL err_ready_sel3: got %b expected 1", cfg_ready); end
        checks++; if (cfg_err !== 1'b0)   begin errors++; $display("FAIL err_pulse_pre: got %b expected 0", cfg_err); end
      end
      if (k == 6) begin
        cfg_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b expected 1", cfg_err); end
      end
      if (k == 7) begin
        cfg_sel = 2'd0;
        #1;
        checks++; if (cfg_err !== 1'b0)   begin errors++; $display("FAIL err_pulse_post: got %b expected 0", cfg_err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL err_ready_sel0: got %b expected 1", cfg_ready); end
      end
      if (k == 33) run = 1'b0;
      if (k == 83) run = 1'b1;
      if (k >= 33 && k <= 83) begin
        checks++; if (sq[1:0] !== 2'b11) begin errors++; $display("FAIL freeze_sq: cycle %0d got %b expected 11", k, sq[1:0]); end
      end
      if (k == 86) begin
        checks++; if (sq[0] !== 1'b0) begin errors++; $display("FAIL resume_sq0: got %b expected 0", sq[0]); end
      end
      tick_clk();
    end
    checks++;
    if (sb[0].size() + sb[1].size() + sb[2].size() != 0) begin
      errors++; $display("FAIL freeze_drain: %0d strobes outstanding, expected 0", sb[0].size() + sb[1].size() + sb[2].size());
    end
    $display("test_err_freeze done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int t = 10; t <= 50; t += 10) sb[0].push_back(t);
    for (int k = 1; k <= 57; k++) begin
      if (k == 55) begin cfg_sel = 2'd0; cfg_div = 12'd4; cfg_valid = 1'b1; end
      if (k == 56) cfg_valid = 1'b0;
      if (k == 57) begin
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b expected 0", cfg_ready); end
      end
      tick_clk();
    end
    checks++;
    if (sb[0].size() + sb[1].size() + sb[2].size() != 0) begin
      errors++; $display("FAIL rstmid_pre_drain: %0d strobes outstanding, expected 0", sb[0].size() + sb[1].size() + sb[2].size());
    end
    do_reset();
    for (int t = 10; t <= 60; t += 10) sb[0].push_back(t);
    for (int k = 1; k <= 60; k++) begin
      if (k == 1) begin
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", cfg_ready); end
      end
      checks++;
      if (applied !== 3'b000) begin errors++; $display("FAIL rstmid_applied: cycle %0d got %b expected 000", k, applied); end
      tick_clk();
    end
    checks++;
    if (sb[0].size() + sb[1].size() + sb[2].size() != 0) begin
      errors++; $display("FAIL rstmid_drain: %0d strobes outstanding, expected 0", sb[0].size() + sb[1].size() + sb[2].size());
    end
    $display("test_reset_mid done, checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_reprogram();
    test_back_to_back();
    test_disable();
    test_err_freeze();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Single-clock replacement for the cascaded frequency-divider tree on the smallcar board.
- Generates three timebase channels from the 100 MHz system clock, each as a one-cycle enable strobe and a square-wave level. Consumers use the strobes as clock enables, so the design needs no derived clocks.
- Divide constants can be reprogrammed at runtime through a valid/ready port. A new value takes effect only at a period boundary, so no runt period ever appears.

Parameters:
- DIV0_RST, 10, channel 0 divide constant after reset (10 MHz).
- DIV1_RST, 100, channel 1 divide constant after reset (1 MHz).
- DIV2_RST, 100, channel 2 divide constant after reset (10 kHz when cascaded).
- CASCADE, 1, 1: channel 2 steps on channel 1 tick; 0: channel 2 steps every cycle.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- run  input  1  1: counters advance; 0: counters frozen, ticks forced 0.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accepted when cfg_valid & cfg_ready.
- cfg_sel  input  2  channel 0..2; value 3 is invalid.
- cfg_div  input  12  new divide constant.
- cfg_err  output  1  one-cycle pulse on an accepted write with cfg_sel=3.
- tick  output  3  per-channel one-cycle strobe, once per period.
- sq  output  3  per-channel square wave.
- applied  output  3  one-cycle pulse when a pending constant becomes active.

Behaviour:
- Per-channel state:
  - active divisor act[i] (12b);
  - pending divisor pend[i] (12b) with flag pv[i];
  - counter cnt[i] (12b).
- Reset (rst=1 at a clk_in edge):
  - cnt=0, pv=0, act[i]=DIVi_RST;
  - tick=0, sq=0, applied=0, cfg_err=0.
  - Reset mid-operation discards pending writes and any partial period.
- Step enable:
  - step0 = step1 = run.
  - step2 = run & tick[1] if CASCADE=1, otherwise run.
  - tick[1] here is the combinational wrap condition of channel 1 in the same cycle.
- Counting, for act[i]>=1:
  - When step[i]=1: if cnt==act-1 then tick[i]=1 and cnt<=0, else cnt<=cnt+1.
  - tick is combinational from cnt and step, asserted exactly in the wrap cycle.
  - First tick for N=10 with run held 1: 10th cycle after rst deassertion, then every 10 cycles.
- Square wave: sq[i] is registered and equals 1 when cnt < act>>1.
  - Even N gives 50% duty; odd N is high for floor(N/2) of N steps.
  - N=1 gives sq=0 with tick on every step.
- Disabled channel (act[i]==0): cnt held 0, tick=0, sq=0.
- Config handshake:
  - cfg_ready = ~pv[cfg_sel] for sel 0..2; cfg_ready = 1 for sel=3.
  - Accept with sel 0..2: pend<=cfg_div, pv<=1.
  - Accept with sel=3: no state change; cfg_err pulses the next cycle.
- Apply rule:
  - A pending value is applied on the first wrap cycle (tick[i]=1) after the accept cycle. Then act<=pend, pv<=0, cnt<=0, and applied[i] pulses the next cycle.
  - If act[i]==0, the pending value is applied the cycle after accept, regardless of run.
  - If run=0 and act!=0, the apply waits until counting resumes and wraps.
- Simultaneous events:
  - An accept in the same cycle as a wrap of that channel does not apply at that wrap. It waits for the next wrap.
  - Writing cfg_div=0 disables the channel at the apply point.
  - A cascaded channel 2 keeps its own cnt when channel 1 is reprogrammed; only its step rate changes.
- No combinational path from cfg_valid to cfg_ready.

Test Plan:
1. Defaults, CASCADE=1, run=1 for 30000 cycles after reset:
   - tick[0] every 10 cycles, first at cycle 10;
   - tick[1] every 100 cycles;
   - tick[2] every 10000 cycles;
   - sq[0] high 5 / low 5.
2. Reprogram channel 0 to 4 mid-period, at cnt=3:
   - remaining period stays 10;
   - applied[0] pulses the cycle after the wrap;
   - subsequent tick[0] every 4 cycles;
   - cfg_ready[sel=0] is low until the apply.
3. Accept a write to channel 1 in its wrap cycle:
   - the old period of 100 completes once more;
   - the new value applies at the following wrap.
4. Write 0 to channel 2, then 7 while it is disabled:
   - after the next wrap, tick[2] and sq[2] stay 0;
   - the value 7 applies 1 cycle after its accept;
   - tick[2] follows at 7 channel-1 ticks.
5. cfg_sel=3 write -> cfg_err is a single pulse and no channel changes; run=0 for 50 cycles -> all ticks 0 and counters frozen, resuming from the same cnt.
6. rst asserted with pv[0]=1 and cnt[1]=57:
   - all state returns to defaults;
   - the pending value is lost;
   - the first tick[0] comes 10 cycles after rst falls.
